breath_led_multi: RTL and testbench



---
 rtl/breath_led_multi.sv | 227 ++++++++++++++++++++++
 tb/tb_breath_led_multi.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/breath_led_multi.sv
// breath_led_multi
//   Multi-channel PWM LED driver. A shared prescaler and PWM period counter
//   time NUM_CH channels, each with its own mode (off/on/breath/blink) and
//   ramp step. Configuration arrives through a one-entry pending slot that
//   is applied at the next PWM period boundary.
//
// Ports
//   sys_clk     system clock
//   sys_rst_n   asynchronous active-low reset
//   sw_ctrl     per-channel output enable (1 = LED may light), unregistered
//   cfg_valid   config request
//   cfg_ready   config slot free
//   cfg_ch      target channel
//   cfg_mode    0 off, 1 on, 2 breath, 3 blink
//   cfg_step    requested ramp step (clamped to 1..MAX_STEP)
//   cfg_err     one-cycle pulse when an accepted request named a bad channel
//   period_stb  one-cycle pulse in the first cycle of each PWM period
//   led         LED drive
module breath_led_multi #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int TICK_DIV   = 100,
  parameter int PWM_RES    = 1000,
  parameter int DUTY_W     = 10,
  parameter int MAX_STEP   = 10,
  parameter int START_STEP = 1,
  parameter int RESET_MODE = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [NUM_CH-1:0] sw_ctrl,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [DUTY_W-1:0] cfg_step,
  output logic              cfg_err,
  output logic              period_stb,
  output logic [NUM_CH-1:0] led
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_ON     = 2'd1,
    MODE_BREATH = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam int                PRE_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]  TICK_LAST    = PRE_W'(TICK_DIV - 1);
  localparam logic [DUTY_W-1:0] PWM_LAST     = DUTY_W'(PWM_RES - 1);
  localparam logic [DUTY_W:0]   PWM_LAST_X   = (DUTY_W + 1)'(PWM_RES - 1);
  localparam logic [DUTY_W-1:0] MAX_STEP_L   = DUTY_W'(MAX_STEP);
  localparam logic [DUTY_W-1:0] START_STEP_L = DUTY_W'(START_STEP);
  localparam logic [1:0]        RESET_MODE_L = 2'(RESET_MODE);
  localparam logic [CH_W:0]     NUM_CH_L     = (CH_W + 1)'(NUM_CH);

  logic [PRE_W-1:0]  prescaler_q, prescaler_d;
  logic [DUTY_W-1:0] pwmCnt_q, pwmCnt_d;
  logic              tick;
  logic              pend;

  mode_e             mode_q [NUM_CH];
  mode_e             mode_d [NUM_CH];
  logic [DUTY_W-1:0] step_q [NUM_CH];
  logic [DUTY_W-1:0] step_d [NUM_CH];
  logic [DUTY_W-1:0] duty_q [NUM_CH];
  logic [DUTY_W-1:0] duty_d [NUM_CH];
  logic [DUTY_W:0]   rampSum [NUM_CH];
  logic [NUM_CH-1:0] dirDown_q, dirDown_d;
  logic [NUM_CH-1:0] ledR_q, ledR_d;

  logic              pendValid_q, pendValid_d;
  logic [CH_W-1:0]   pendCh_q, pendCh_d;
  mode_e             pendMode_q, pendMode_d;
  logic [DUTY_W-1:0] pendStep_q, pendStep_d;
  logic              cfgErr_q, cfgErr_d;
  logic              periodStb_q, periodStb_d;

  logic              accept;
  logic              chBad;
  logic [DUTY_W-1:0] stepClamped;

  // Shared timebase: prescaler produces one tick every TICK_DIV clocks, the
  // PWM counter steps on ticks; pend marks the last clock of a PWM period.
  assign tick = (prescaler_q == TICK_LAST);
  assign pend = tick & (pwmCnt_q == PWM_LAST);

  always_comb begin
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    pwmCnt_d    = pwmCnt_q;
    if (tick) begin
      pwmCnt_d = (pwmCnt_q == PWM_LAST) ? '0 : pwmCnt_q + 1'b1;
    end
  end

  // Config slot. The slot is free whenever nothing is pending, so a request
  // accepted in a pend cycle naturally waits for the following pend.
  assign accept = cfg_valid & ~pendValid_q;
  assign chBad  = ({1'b0, cfg_ch} >= NUM_CH_L);

  always_comb begin
    stepClamped = cfg_step;
    if (cfg_step == '0) begin
      stepClamped = DUTY_W'(1);
    end else if (cfg_step > MAX_STEP_L) begin
      stepClamped = MAX_STEP_L;
    end
  end

  always_comb begin
    pendValid_d = pendValid_q;
    pendCh_d    = pendCh_q;
    pendMode_d  = pendMode_q;
    pendStep_d  = pendStep_q;
    cfgErr_d    = accept & chBad;
    periodStb_d = pend;
    if (pend) begin
      pendValid_d = 1'b0;
    end
    if (accept & ~chBad) begin
      pendValid_d = 1'b1;
      pendCh_d    = cfg_ch;
      pendMode_d  = mode_e'(cfg_mode);
      pendStep_d  = stepClamped;
    end
  end

  // Extended-width sum so the up ramp can detect reaching full scale
  // without wrapping.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      rampSum[i] = {1'b0, duty_q[i]} + {1'b0, step_q[i]};
    end
  end

  // Per-channel state: a pending config replaces the channel's ramp for the
  // period in which it lands; otherwise breath/blink channels ramp on pend.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      mode_d[i]    = mode_q[i];
      step_d[i]    = step_q[i];
      duty_d[i]    = duty_q[i];
      dirDown_d[i] = dirDown_q[i];
      if (pend & pendValid_q & (pendCh_q == CH_W'(i))) begin
        mode_d[i]    = pendMode_q;
        step_d[i]    = pendStep_q;
        duty_d[i]    = '0;
        dirDown_d[i] = 1'b0;
      end else if (pend & ((mode_q[i] == MODE_BREATH) | (mode_q[i] == MODE_BLINK))) begin
        if (!dirDown_q[i]) begin
          if (rampSum[i] >= PWM_LAST_X) begin
            duty_d[i]    = PWM_LAST;
            dirDown_d[i] = 1'b1;
          end else begin
            duty_d[i] = rampSum[i][DUTY_W-1:0];
          end
        end else begin
          if (duty_q[i] <= step_q[i]) begin
            duty_d[i]    = '0;
            dirDown_d[i] = 1'b0;
          end else begin
            duty_d[i] = duty_q[i] - step_q[i];
          end
        end
      end
    end
  end

  // LED pattern. On the down ramp the compare is inclusive so the peak
  // period is fully lit and the ramp stays symmetric.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ledR_d[i] = 1'b0;
      case (mode_q[i])
        MODE_OFF:    ledR_d[i] = 1'b0;
        MODE_ON:     ledR_d[i] = 1'b1;
        MODE_BREATH: ledR_d[i] = dirDown_q[i] ? (pwmCnt_q <= duty_q[i]) : (pwmCnt_q < duty_q[i]);
        MODE_BLINK:  ledR_d[i] = ~dirDown_q[i];
        default:     ledR_d[i] = 1'b0;
      endcase
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prescaler_q <= '0;
      pwmCnt_q    <= '0;
      dirDown_q   <= '0;
      ledR_q      <= '0;
      pendValid_q <= 1'b0;
      pendCh_q    <= '0;
      pendMode_q  <= MODE_OFF;
      pendStep_q  <= START_STEP_L;
      cfgErr_q    <= 1'b0;
      periodStb_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= mode_e'(RESET_MODE_L);
        step_q[i] <= START_STEP_L;
        duty_q[i] <= '0;
      end
    end else begin
      prescaler_q <= prescaler_d;
      pwmCnt_q    <= pwmCnt_d;
      dirDown_q   <= dirDown_d;
      ledR_q      <= ledR_d;
      pendValid_q <= pendValid_d;
      pendCh_q    <= pendCh_d;
      pendMode_q  <= pendMode_d;
      pendStep_q  <= pendStep_d;
      cfgErr_q    <= cfgErr_d;
      periodStb_q <= periodStb_d;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= mode_d[i];
        step_q[i] <= step_d[i];
        duty_q[i] <= duty_d[i];
      end
    end
  end

  assign cfg_ready  = ~pendValid_q;
  assign cfg_err    = cfgErr_q;
  assign period_stb = periodStb_q;
  assign led        = ledR_q & sw_ctrl;

endmodule

// File: tb/tb_breath_led_multi.sv
// tb_breath_led_multi
//   Self-checking bench for breath_led_multi with a small configuration
//   (2 channels, 16-clock PWM period). A behavioural reference derives the
//   timebase from the elapsed cycle count and the channel ramps from plain
//   integer arithmetic.
module tb_breath_led_multi;

  localparam int NUM_CH     = 2;
  localparam int CH_W       = 2;
  localparam int TICK_DIV   = 2;
  localparam int PWM_RES    = 8;
  localparam int DUTY_W     = 4;
  localparam int MAX_STEP   = 3;
  localparam int START_STEP = 1;
  localparam int RESET_MODE = 2;
  localparam int PERIOD     = TICK_DIV * PWM_RES;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [NUM_CH-1:0] sw_ctrl;
  logic              cfg_valid;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_mode;
  logic [DUTY_W-1:0] cfg_step;
  wire               cfg_ready;
  wire               cfg_err;
  wire               period_stb;
  wire  [NUM_CH-1:0] led;

  int errors = 0;
  int checks = 0;

  breath_led_multi #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .TICK_DIV(TICK_DIV), .PWM_RES(PWM_RES),
    .DUTY_W(DUTY_W), .MAX_STEP(MAX_STEP), .START_STEP(START_STEP),
    .RESET_MODE(RESET_MODE)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sw_ctrl(sw_ctrl),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_step(cfg_step), .cfg_err(cfg_err),
    .period_stb(period_stb), .led(led)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model state
  int              mCyc;
  int              mMode [NUM_CH];
  int              mStep [NUM_CH];
  int              mDuty [NUM_CH];
  bit              mDown [NUM_CH];
  bit [NUM_CH-1:0] mLedR;
  bit              mStb, mErr, mPendValid;
  int              mPendCh, mPendMode, mPendStep;
  int              mPwm;
  bit              mPend, mAccept;

  function automatic bit ledRule(int mode, int duty, bit down, int pwm);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return down ? (pwm <= duty) : (pwm < duty);
      default: return !down;
    endcase
  endfunction

  function automatic int clampStep(int s);
    if (s == 0) return 1;
    if (s > MAX_STEP) return MAX_STEP;
    return s;
  endfunction

  // The timebase is a pure function of clocks elapsed since reset release.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mCyc = 0; mStb = 0; mErr = 0; mPendValid = 0; mLedR = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        mMode[i] = RESET_MODE; mStep[i] = START_STEP; mDuty[i] = 0; mDown[i] = 0;
      end
    end else begin
      mPwm    = (mCyc / TICK_DIV) % PWM_RES;
      mPend   = (mCyc % PERIOD) == PERIOD - 1;
      mAccept = cfg_valid && !mPendValid;
      for (int i = 0; i < NUM_CH; i++) mLedR[i] = ledRule(mMode[i], mDuty[i], mDown[i], mPwm);
      if (mPend) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (mPendValid && mPendCh == i) begin
            mMode[i] = mPendMode; mStep[i] = mPendStep; mDuty[i] = 0; mDown[i] = 0;
          end else if (mMode[i] >= 2) begin
            if (!mDown[i]) begin
              if (mDuty[i] + mStep[i] >= PWM_RES - 1) begin mDuty[i] = PWM_RES - 1; mDown[i] = 1; end
              else mDuty[i] = mDuty[i] + mStep[i];
            end else begin
              if (mDuty[i] <= mStep[i]) begin mDuty[i] = 0; mDown[i] = 0; end
              else mDuty[i] = mDuty[i] - mStep[i];
            end
          end
        end
        mPendValid = 0;
      end
      mErr = mAccept && (int'(cfg_ch) >= NUM_CH);
      if (mAccept && int'(cfg_ch) < NUM_CH) begin
        mPendValid = 1; mPendCh = int'(cfg_ch); mPendMode = int'(cfg_mode);
        mPendStep = clampStep(int'(cfg_step));
      end
      mStb = mPend;
      mCyc++;
    end
  end

  wire  [NUM_CH+2:0] obsVec = {led, period_stb, cfg_ready, cfg_err};
  logic [NUM_CH+2:0] expVec;
  assign expVec = {mLedR & sw_ctrl, mStb, !mPendValid, mErr};

  // Drives one request and holds it until the slot is free; returns on the
  // falling edge right after acceptance with cfg_valid already dropped.
  task automatic send_cfg(input int ch, input int mode, input int step);
    int n = 0;
    cfg_ch = CH_W'(ch); cfg_mode = 2'(mode); cfg_step = DUTY_W'(step); cfg_valid = 1'b1;
    while (cfg_ready !== 1'b1 && n < 4 * PERIOD) begin @(negedge sys_clk); n++; end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL cfg_timeout: ready=%b required 1", cfg_ready); end
    @(negedge sys_clk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n = 0;
    int cnt;
    int expCnt [15] = '{2, 4, 6, 8, 10, 12, 16, 14, 12, 10, 8, 6, 4, 0, 2};
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (obsVec !== 5'b00010) begin errors++; $display("[TB] FAIL reset_values: got %b required 00010", obsVec); end
    sys_rst_n = 1'b1;
    do begin @(negedge sys_clk); n++; end while (period_stb !== 1'b1 && n < 2 * PERIOD);
    checks++;
    if (n !== PERIOD) begin errors++; $display("[TB] FAIL first_stb: after %0d clocks required %0d", n, PERIOD); end
    for (int p = 0; p < 15; p++) begin
      cnt = 0;
      for (int s = 1; s <= PERIOD; s++) begin
        @(negedge sys_clk);
        cnt += int'(led[0]);
        checks++;
        if (obsVec !== expVec) begin errors++; $display("[TB] FAIL ramp_model: got %b required %b", obsVec, expVec); end
        checks++;
        if (period_stb !== (s == PERIOD)) begin errors++; $display("[TB] FAIL stb_spacing: got %b at clock %0d", period_stb, s); end
      end
      checks++;
      if (cnt != expCnt[p]) begin errors++; $display("[TB] FAIL breath_window p%0d: lit %0d required %0d", p, cnt, expCnt[p]); end
    end
  endtask

  task automatic test_clamp();
    int n = 0;
    int cnt;
    int expCnt [8] = '{0, 6, 12, 16, 10, 4, 0, 6};
    send_cfg(1, 2, 9);
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_drop: got %b required 0", cfg_ready); end
    do begin
      @(negedge sys_clk); n++;
      if (period_stb !== 1'b1) begin
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_low: got %b required 0", cfg_ready); end
      end
    end while (period_stb !== 1'b1 && n < 2 * PERIOD);
    checks++;
    if (cfg_ready !== 1'b1 || period_stb !== 1'b1) begin
      errors++; $display("[TB] FAIL ready_return: ready=%b stb=%b required 1 1", cfg_ready, period_stb);
    end
    for (int p = 0; p < 8; p++) begin
      cnt = 0;
      for (int s = 1; s <= PERIOD; s++) begin
        @(negedge sys_clk);
        cnt += int'(led[1]);
        checks++;
        if (obsVec !== expVec) begin errors++; $display("[TB] FAIL clamp_model: got %b required %b", obsVec, expVec); end
      end
      checks++;
      if (cnt != expCnt[p]) begin errors++; $display("[TB] FAIL clamp_window p%0d: lit %0d required %0d", p, cnt, expCnt[p]); end
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    send_cfg(0, 1, 1);
    send_cfg(0, 0, 1);
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_accept: ready=%b required 0", cfg_ready); end
    cnt = int'(led[0]);
    for (int s = 1; s < PERIOD; s++) begin
      @(negedge sys_clk);
      cnt += int'(led[0]);
      checks++;
      if (obsVec !== expVec) begin errors++; $display("[TB] FAIL on_model: got %b required %b", obsVec, expVec); end
    end
    checks++;
    if (cnt != PERIOD) begin errors++; $display("[TB] FAIL on_window: lit %0d required %0d", cnt, PERIOD); end
    cnt = 0;
    for (int s = 0; s < PERIOD; s++) begin
      @(negedge sys_clk);
      cnt += int'(led[0]);
    end
    checks++;
    if (cnt != 0) begin errors++; $display("[TB] FAIL off_window: lit %0d required 0", cnt); end
  endtask

  task automatic test_bad_channel();
    send_cfg(3, 1, 2);
    checks++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL bad_ch_pulse: err=%b ready=%b required 1 1", cfg_err, cfg_ready);
    end
    @(negedge sys_clk);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL bad_ch_single: err=%b required 0", cfg_err); end
    for (int s = 0; s < 2 * PERIOD; s++) begin
      @(negedge sys_clk);
      checks++;
      if (obsVec !== expVec) begin errors++; $display("[TB] FAIL bad_ch_model: got %b required %b", obsVec, expVec); end
    end
  endtask

  task automatic test_blink();
    int n = 0;
    int cnt;
    send_cfg(0, 3, 0);
    do begin @(negedge sys_clk); n++; end while (period_stb !== 1'b1 && n < 2 * PERIOD);
    checks++;
    if (period_stb !== 1'b1) begin errors++; $display("[TB] FAIL blink_stb_timeout: stb=%b required 1", period_stb); end
    for (int p = 0; p < 14; p++) begin
      cnt = 0;
      for (int s = 1; s <= PERIOD; s++) begin
        @(negedge sys_clk);
        cnt += int'(led[0]);
        checks++;
        if (obsVec !== expVec) begin errors++; $display("[TB] FAIL blink_model: got %b required %b", obsVec, expVec); end
      end
      checks++;
      if (cnt != ((p < 7) ? PERIOD : 0)) begin
        errors++; $display("[TB] FAIL blink_window p%0d: lit %0d required %0d", p, cnt, (p < 7) ? PERIOD : 0);
      end
    end
  endtask

  task automatic test_gate_and_reset();
    int n = 0;
    @(negedge sys_clk);
    sw_ctrl[1] = 1'b0;
    #1;
    checks++;
    if (led[1] !== 1'b0) begin errors++; $display("[TB] FAIL sw_gate: led1=%b required 0", led[1]); end
    for (int s = 0; s < 20; s++) begin
      @(negedge sys_clk);
      checks++;
      if (obsVec !== expVec) begin errors++; $display("[TB] FAIL gate_model: got %b required %b", obsVec, expVec); end
    end
    sw_ctrl = '1;
    do begin @(negedge sys_clk); n++; end while (period_stb !== 1'b1 && n < 2 * PERIOD);
    send_cfg(1, 1, 1);
    repeat (4) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (obsVec !== 5'b00010) begin errors++; $display("[TB] FAIL async_reset: got %b required 00010", obsVec); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int s = 0; s < 3 * PERIOD; s++) begin
      @(negedge sys_clk);
      checks++;
      if (obsVec !== expVec) begin errors++; $display("[TB] FAIL post_reset_model: got %b required %b", obsVec, expVec); end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 600; s++) begin
      @(negedge sys_clk);
      checks++;
      if (obsVec !== expVec) begin errors++; $display("[TB] FAIL random_model: got %b required %b", obsVec, expVec); end
      cfg_valid = ($urandom_range(3) == 0);
      cfg_ch    = CH_W'($urandom_range(3));
      cfg_mode  = 2'($urandom_range(3));
      cfg_step  = DUTY_W'($urandom_range(15));
      if ((s % 50) == 0) sw_ctrl = NUM_CH'($urandom_range(3));
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    sw_ctrl   = '1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_mode  = '0;
    cfg_step  = '0;
    test_reset();
    test_clamp();
    test_back_to_back();
    test_bad_channel();
    test_blink();
    test_gate_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
